sync_fifo_rf: RTL and testbench
===============================

SYNC_FIFO_RF -- requirements
Module: sync_fifo_rf

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of depth (DEPTH = 2**ADDR_WIDTH).
REQ-003 The block SHALL have parameter AFULL_LEVEL, default DEPTH-2, meaning almost_full asserts when count >= AFULL_LEVEL.
REQ-004 The block SHALL have parameter AEMPTY_LEVEL, default 2, meaning almost_empty asserts when count <= AEMPTY_LEVEL.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port wr, input, 1 bit: push request.
REQ-008 The block SHALL have port w_data, input, DATA_BITS bits: push data.
REQ-009 The block SHALL have port rd, input, 1 bit: pop request (acknowledges the current r_data).
REQ-010 The block SHALL have port clr_err, input, 1 bit: clears sticky error flags.
REQ-011 The block SHALL have port r_data, output, DATA_BITS bits: head word (first-word fall-through).
REQ-012 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status.
REQ-013 The block SHALL have port count, output, ADDR_WIDTH+1 bits: words stored, 0..DEPTH.
REQ-014 The block SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-015 Storage SHALL be DEPTH x DATA_BITS, written synchronously and read combinationally at the read pointer.
REQ-016 Write and read pointers SHALL each be ADDR_WIDTH+1 bits, incrementing modulo 2**(ADDR_WIDTH+1); their low ADDR_WIDTH bits address storage.
REQ-017 empty SHALL be 1 when pointers are equal; full SHALL be 1 when the low bits are equal and the MSBs differ.
REQ-018 count SHALL equal wr_ptr - rd_ptr, computed in ADDR_WIDTH+1 bits; all status outputs SHALL be combinational from the registered pointers.
REQ-019 An accepted push (wr & !full, or wr & rd & full) SHALL write w_data at the write pointer and advance it at the same edge.
REQ-020 An accepted pop (rd & !empty) SHALL advance the read pointer; the next head SHALL appear on r_data in the following cycle.
REQ-021 With wr & rd & full, both operations SHALL complete, count SHALL stay DEPTH, and overflow SHALL NOT set.
REQ-022 With wr & rd & empty, only the push SHALL complete, count SHALL become 1, and underflow SHALL set.
REQ-023 With wr & !rd & full, the push SHALL be dropped, storage and pointers SHALL be unchanged, and overflow SHALL set.
REQ-024 With rd & empty, the pointers SHALL be unchanged and underflow SHALL set.
REQ-025 r_data SHALL be don't-care while empty, and the bench SHALL NOT check it then.
REQ-026 overflow and underflow SHALL hold until clr_err=1 or reset; if clr_err and a new error event occur in the same cycle, the flag SHALL be 1 afterwards.
REQ-027 Pointer wrap-around SHALL be seamless, with no bubble and no loss of data.

Reset
REQ-028 On reset=1 at a clk edge, both pointers SHALL be 0 and both error flags SHALL be 0, giving empty=1, almost_empty=1, full=0, almost_full=0, count=0.
REQ-029 Reset SHALL take priority over wr, rd and clr_err in the same cycle, including reset asserted mid-stream.
REQ-030 Storage contents SHALL NOT be reset.

Structure
REQ-031 A shared package fifo_pkg SHALL hold the default depth and width constants and a status struct type {full, empty, almost_full, almost_empty}.
REQ-032 Storage SHALL be a single sub-module, fifo_storage, parametrised by DATA_BITS and ADDR_WIDTH, with ports clk, w_en, w_addr, w_data, r_addr and r_data.
REQ-033 Pointer, flag and error logic SHALL reside in sync_fifo_rf itself.

Verification (defaults: DEPTH 16, AFULL 14, AEMPTY 2)
REQ-034 Pushing 0x01..0x10 then popping 16 SHALL return 0x01..0x10 in order; after the 16th push full=1 and count=16, and after the 16th pop empty=1.
REQ-035 Pushing 14 words SHALL take almost_full from 0 to 1 on the 14th push; popping from 3 words down to 2 SHALL assert almost_empty.
REQ-036 A 17th push while full SHALL set overflow=1, keep count=16, and still pop out 0x01 first; a subsequent clr_err SHALL clear overflow to 0.
REQ-037 wr&rd when full SHALL keep count=16 with overflow=0; wr&rd when empty with w_data=0xA5 SHALL give count=1, r_data=0xA5 and underflow=1.
REQ-038 Forty interleaved push/pop cycles holding count at 3 SHALL wrap the pointers at least twice with the data order preserved.
REQ-039 Reset after 5 pushes SHALL give count=0, empty=1, error flags 0 in the next cycle, and a fresh push of 0x3C SHALL appear on r_data.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and the status bundle type
package fifo_pkg;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;
endpackage

// File: rtl/fifo_storage.sv
// fifo_storage: DEPTH x DATA_BITS array, synchronous write, combinational read
module fifo_storage #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_BITS-1:0]  w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_BITS-1:0]  r_data
);
  logic [DATA_BITS-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (w_en) mem[w_addr] <= w_data;
  assign r_data = mem[r_addr];
endmodule

// File: rtl/sync_fifo_rf.sv
// sync_fifo_rf: first-word fall-through synchronous FIFO with status and sticky error flags
module sync_fifo_rf
  import fifo_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AFULL_LEVEL = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_BITS-1:0]  w_data,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [DATA_BITS-1:0]  r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] AF = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE = AEMPTY_LEVEL[ADDR_WIDTH:0];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ovf_q, ovf_d, udf_q, udf_d, do_wr, do_rd;
  status_t st;
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    st.empty = wr_ptr_q == rd_ptr_q;
    st.full = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    st.almost_full = count >= AF;
    st.almost_empty = count <= AE;
    do_wr = wr && (!st.full || rd);
    do_rd = rd && !st.empty;
    wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, do_rd};
    ovf_d = (wr && !rd && st.full) || (ovf_q && !clr_err);
    udf_d = (rd && st.empty) || (udf_q && !clr_err);
  end
  assign {full, empty, almost_full, almost_empty} = st;
  assign overflow = ovf_q;
  assign underflow = udf_q;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  fifo_storage #(.DATA_BITS(DATA_BITS), .ADDR_WIDTH(ADDR_WIDTH)) u_storage (
    .clk(clk),
    .w_en(do_wr),
    .w_addr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .w_data(w_data),
    .r_addr(rd_ptr_q[ADDR_WIDTH-1:0]),
    .r_data(r_data)
  );
endmodule

// File: tb/tb_sync_fifo_rf.sv
// tb_sync_fifo_rf: scenario tasks checking sync_fifo_rf against a queue scoreboard
module tb_sync_fifo_rf;
  logic clk = 0, reset = 0, wr = 0, rd = 0, clr_err = 0;
  logic [7:0] w_data = 0, r_data;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int total = 0, bad = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_d;
  sync_fifo_rf dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd), .clr_err(clr_err),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c, input logic rs);
    bit fm, em;
    wr = w; rd = r; w_data = d; clr_err = c; reset = rs;
    fm = sb.size() == 16;
    em = sb.size() == 0;
    if (rs) sb.delete();
    else begin
      if (r && !em) void'(sb.pop_front());
      if (w && (!fm || r)) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    wr = 0; rd = 0; clr_err = 0; reset = 0;
  endtask
  task automatic test_reset;
    step(0, 0, 8'h00, 0, 1);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({full, empty, almost_full, almost_empty, overflow, underflow} !== 6'b010100) begin
      bad++; $display("FAIL reset_flags got=%b exp=010100", {full, empty, almost_full, almost_empty, overflow, underflow});
    end
  endtask
  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), 0, 0);
    total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL fill_full got full=%b count=%0d exp 1/16", full, count); end
    for (int i = 0; i < 16; i++) begin
      exp_d = sb[0];
      total++; if (r_data !== exp_d) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, r_data, exp_d); end
      step(0, 1, 8'h00, 0, 0);
      total++; if (count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 15 - i); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask
  task automatic test_thresholds;
    for (int i = 0; i < 13; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL af_13 got=%b exp=0", almost_full); end
    step(1, 0, 8'h4D, 0, 0);
    total++; if (almost_full !== 1'b1 || count !== 5'd14) begin bad++; $display("FAIL af_14 got af=%b count=%0d exp 1/14", almost_full, count); end
    while (sb.size() > 3) begin
      exp_d = sb[0];
      total++; if (r_data !== exp_d) begin bad++; $display("FAIL thr_data got=%h exp=%h", r_data, exp_d); end
      step(0, 1, 8'h00, 0, 0);
    end
    total++; if (almost_empty !== 1'b0 || count !== 5'd3) begin bad++; $display("FAIL ae_3 got ae=%b count=%0d exp 0/3", almost_empty, count); end
    step(0, 1, 8'h00, 0, 0);
    total++; if (almost_empty !== 1'b1 || count !== 5'd2) begin bad++; $display("FAIL ae_2 got ae=%b count=%0d exp 1/2", almost_empty, count); end
    while (sb.size() > 0) step(0, 1, 8'h00, 0, 0);
  endtask
  task automatic test_overflow;
    for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 0, 8'h77, 0, 0);
    total++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_set got ovf=%b count=%0d exp 1/16", overflow, count); end
    step(1, 0, 8'h78, 1, 0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_clr_and_event got=%b exp=1", overflow); end
    total++; if (r_data !== 8'h01) begin bad++; $display("FAIL ovf_head got=%h exp=01", r_data); end
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    while (sb.size() > 0) begin
      exp_d = sb[0];
      total++; if (r_data !== exp_d) begin bad++; $display("FAIL ovf_drain got=%h exp=%h", r_data, exp_d); end
      step(0, 1, 8'h00, 0, 0);
    end
  endtask
  task automatic test_simul;
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h90 + i), 0, 0);
    exp_d = sb[0];
    total++; if (r_data !== exp_d) begin bad++; $display("FAIL simfull_head got=%h exp=%h", r_data, exp_d); end
    step(1, 1, 8'hB0, 0, 0);
    total++; if (count !== 5'd16 || overflow !== 1'b0) begin bad++; $display("FAIL simfull got count=%0d ovf=%b exp 16/0", count, overflow); end
    while (sb.size() > 0) begin
      exp_d = sb[0];
      total++; if (r_data !== exp_d) begin bad++; $display("FAIL simfull_drain got=%h exp=%h", r_data, exp_d); end
      step(0, 1, 8'h00, 0, 0);
    end
    step(1, 1, 8'hA5, 0, 0);
    total++; if (count !== 5'd1 || r_data !== 8'hA5 || underflow !== 1'b1) begin
      bad++; $display("FAIL simempty got count=%0d data=%h udf=%b exp 1/a5/1", count, r_data, underflow);
    end
    step(0, 1, 8'h00, 1, 0);
    total++; if (underflow !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL udf_clear got udf=%b empty=%b exp 0/1", underflow, empty); end
  endtask
  task automatic test_wrap;
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      exp_d = sb[0];
      total++; if (r_data !== exp_d) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, r_data, exp_d); end
      step(1, 1, 8'($urandom_range(0, 255)), 0, 0);
      total++; if (count !== 5'd3) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=3", i, count); end
    end
    while (sb.size() > 0) begin
      exp_d = sb[0];
      total++; if (r_data !== exp_d) begin bad++; $display("FAIL wrap_drain got=%h exp=%h", r_data, exp_d); end
      step(0, 1, 8'h00, 0, 0);
    end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hE0 + i), 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(1, 1, 8'h55, 0, 1);
    total++; if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL midreset got count=%0d empty=%b ovf=%b udf=%b exp 0/1/0/0", count, empty, overflow, underflow);
    end
    step(1, 0, 8'h3C, 0, 0);
    total++; if (r_data !== 8'h3C || count !== 5'd1) begin bad++; $display("FAIL post_reset got data=%h count=%0d exp 3c/1", r_data, count); end
  endtask
  initial begin
    test_reset;
    test_fill_drain;
    test_thresholds;
    test_overflow;
    test_simul;
    test_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
